// File: rtl/riscv_pkg.sv
// Shared RISC-V trace types: data width, opcode constants, the record
// classification enum, the stored trace record, and the store-data narrowing helper.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;

  typedef enum logic [2:0] {
    TR_ALU   = 3'd0,
    TR_LOAD  = 3'd1,
    TR_STORE = 3'd2,
    TR_NOP   = 3'd3,
    TR_STALL = 3'd4,
    TR_FLUSH = 3'd5
  } trace_kind_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    trace_kind_e     kind;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } trace_rec_t;

  // Zero-extend store data to the access size given by funct3. Any funct3
  // other than byte/half keeps the full word.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0]      funct3,
                                                 input logic [XLEN-1:0] data);
    logic [XLEN-1:0] res;
    res = data;
    case (funct3)
      F3_BYTE: res = {{(XLEN-8){1'b0}},  data[7:0]};
      F3_HALF: res = {{(XLEN-16){1'b0}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO storing elements of type T. The pointers carry one
// extra bit beyond the index so that full and empty can be told apart when
// the index bits are equal. Occupancy is the pointer difference.
module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  T mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; pops from an empty FIFO are ignored.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance; both wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write. When full with push and pop together, the write lands in
  // the slot being vacated; the outgoing record is read before the edge.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_buffer.sv
// Retirement trace buffer: classifies each committed instruction into a
// compact trace record and queues it for a downstream sink. Overflowing
// records are counted and flagged rather than back-pressuring the pipeline.
//
// Output handshake: rec_o is the head record whenever rec_valid_o is 1 and
// holds steady until the cycle rec_valid_o & rec_ready_i is seen at a rising
// edge, which is the one and only transfer point. rec_valid_o never depends
// on rec_ready_i, and a record pushed this cycle is never presented before
// the next cycle.
module trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter bit FILTER_BUBBLES = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   commit_valid_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  input  logic                   stall_i,
  input  logic                   flushD_i,
  input  logic                   flushE_i,
  output logic                   rec_valid_o,
  input  logic                   rec_ready_i,
  output trace_rec_t             rec_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [15:0]            drop_cnt_o,
  output logic                   overflow_o
);

  trace_rec_t  rec_in;
  logic [6:0]  opcode;
  logic        is_bubble;
  logic        filtered;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        drop;

  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;

  assign opcode = instr_i[6:0];

  // Record classification. Memory opcodes win over hazard flags; stall wins
  // over flush. Fields not meaningful for a kind are stored as zero.
  always_comb begin
    rec_in       = '0;
    rec_in.pc    = pc_i;
    rec_in.instr = instr_i;
    rec_in.kind  = TR_NOP;
    if (opcode == OP_STORE) begin
      rec_in.kind     = TR_STORE;
      rec_in.mem_addr = mem_addr_i;
      rec_in.mem_data = store_data(instr_i[14:12], mem_data_i);
    end else if (opcode == OP_LOAD) begin
      rec_in.kind     = TR_LOAD;
      rec_in.rd       = reg_addr_i;
      rec_in.rd_data  = reg_data_i;
      rec_in.mem_addr = mem_addr_i;
    end else if (stall_i) begin
      rec_in.kind = TR_STALL;
    end else if (flushD_i || flushE_i) begin
      rec_in.kind = TR_FLUSH;
    end else if (reg_addr_i == 5'd0) begin
      rec_in.kind = TR_NOP;
    end else begin
      rec_in.kind    = TR_ALU;
      rec_in.rd      = reg_addr_i;
      rec_in.rd_data = reg_data_i;
    end
  end

  // Bubble filtering happens before the FIFO, so filtered records never
  // occupy space and never count as drops.
  assign is_bubble = (rec_in.kind == TR_STALL) || (rec_in.kind == TR_FLUSH);
  assign filtered  = FILTER_BUBBLES && is_bubble;
  assign accept    = commit_valid_i && !filtered;

  assign rec_valid_o = !fifo_empty;
  assign pop         = rec_valid_o && rec_ready_i;
  assign push        = accept && (!fifo_full || pop);
  assign drop        = accept && fifo_full && !pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (trace_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_in),
    .rdata_o (rec_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // Overflow bookkeeping: saturating drop count and a sticky flag.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Overflow registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, range 2..64.
REQ-002 Parameter FILTER_BUBBLES, default 0; when 1, stall/flush records SHALL NOT be stored.
REQ-003 clk_i  in  1  single clock; all state SHALL be rising-edge.
REQ-004 rst_i  in  1  reset; asynchronous, active-high.
REQ-005 commit_valid_i  in  1  retire record present this cycle.
REQ-006 pc_i, instr_i  in  XLEN each  retired PC and instruction word.
REQ-007 reg_addr_i  in  5  destination register (0 = none).
REQ-008 reg_data_i, mem_addr_i, mem_data_i  in  XLEN each  writeback data, memory address, store data.
REQ-009 stall_i, flushD_i, flushE_i  in  1 each  pipeline hazard flags for this record.
REQ-010 rec_valid_o  out  1  head record available.
REQ-011 rec_ready_i  in  1  sink accepts head record.
REQ-012 rec_o  out  trace_rec_t  head record (pc, instr, kind, rd, rd_data, mem_addr, mem_data).
REQ-013 count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 drop_cnt_o  out  16  records lost to overflow, saturating.
REQ-015 overflow_o  out  1  sticky; set on first drop.

Function
REQ-016 Classification SHALL be combinational on the input: opcode 0100011 -> TR_STORE; 0000011 -> TR_LOAD; else stall_i -> TR_STALL; else flushD_i|flushE_i -> TR_FLUSH; else reg_addr_i==0 -> TR_NOP; else TR_ALU.
REQ-017 Priority SHALL be opcode first, then stall, then flush.
REQ-018 For TR_STORE, mem_data SHALL be zero-extended per funct3: 000 -> [7:0], 001 -> [15:0], 010 -> full word; other funct3 -> full word.
REQ-019 For TR_LOAD and TR_ALU, rd/rd_data SHALL be captured; for TR_STORE, TR_NOP, TR_STALL, TR_FLUSH, rd and rd_data SHALL be stored as 0.
REQ-020 mem_addr SHALL be stored only for TR_LOAD/TR_STORE, else 0.
REQ-021 Push SHALL occur when commit_valid_i=1, record not filtered (REQ-002), and FIFO not full after accounting for same-cycle pop.
REQ-022 Pop SHALL occur when rec_valid_o & rec_ready_i.
REQ-023 A record pushed at edge N SHALL appear on rec_o with rec_valid_o=1 at edge N+1 when FIFO was empty (one-cycle latency).
REQ-024 rec_o SHALL remain stable while rec_valid_o=1 and rec_ready_i=0.
REQ-025 Full with simultaneous push and pop: both SHALL occur; count_o unchanged; no drop.
REQ-026 Empty with push and rec_ready_i=1: no bypass; record SHALL be stored, popped no earlier than next cycle.
REQ-027 Full, push, no pop: record SHALL be dropped; drop_cnt_o +1 saturating at 0xFFFF; overflow_o set.
REQ-028 Filtered records SHALL NOT count as drops.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-030 count_o SHALL equal write pointer minus read pointer at all times.

Reset
REQ-031 On rst_i assertion, pointers, count_o, drop_cnt_o and overflow_o SHALL clear immediately; rec_valid_o SHALL be 0.
REQ-032 Reset mid-operation SHALL discard all stored records; storage array need not be cleared.
REQ-033 First push SHALL be accepted on the first rising edge after rst_i deasserts.

Structure
REQ-034 trace_kind_e (TR_ALU, TR_LOAD, TR_STORE, TR_NOP, TR_STALL, TR_FLUSH) and trace_rec_t SHALL live in riscv_pkg alongside XLEN.
REQ-035 Opcode constants OP_LOAD=0000011 and OP_STORE=0100011 SHALL be package constants.
REQ-036 Storage and pointers SHALL be one sub-module, trace_fifo, parameterised by DEPTH and element type; classification remains in trace_buffer.

Verification
REQ-037 Reset then push addi x5 (pc 0x0, instr 0x00500293, rd_data 0x5), ready=1 -> edge+1 rec_valid_o=1, kind TR_ALU, rd 5, rd_data 0x5; popped next edge, count_o 0.
REQ-038 Push sb (instr 0x00B50023, mem_addr 0x100, mem_data 0xDEADBEEF) -> kind TR_STORE, mem_data 0x000000EF, rd 0; sh variant -> 0x0000BEEF.
REQ-039 ready=0, push DEPTH+3 records -> count_o=DEPTH, drop_cnt_o=3, overflow_o=1; first DEPTH records drained in order.
REQ-040 Full, push and pop same cycle -> count_o stays DEPTH, drop_cnt_o unchanged, new record at tail.
REQ-041 FILTER_BUBBLES=1, push 4 records with stall_i=1 plus 1 ALU -> only ALU stored, drop_cnt_o=0.
REQ-042 Assert rst_i asynchronously with 5 entries stored -> rec_valid_o=0 and count_o=0 before next clock edge; overflow_o cleared.
